full_adder_cell: RTL and testbench



---
 rtl/full_adder_cell_pkg.sv | 7 +
 rtl/fa_bit.sv | 16 +
 rtl/full_adder_cell.sv | 76 +++++++
 tb/tb_full_adder_cell.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/full_adder_cell_pkg.sv
// Shared constants for the full_adder_cell slice.
package full_adder_cell_pkg;

    localparam int unsigned WidthMin = 1;
    localparam int unsigned WidthMax = 64;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder leaf: sum and carry-out of a + b + ci.
module fa_bit (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder_cell.sv
// WIDTH-bit ripple-carry adder built from fa_bit leaves, with an optional
// registered copy of the result qualified by a one-cycle valid flag.
module full_adder_cell
    import full_adder_cell_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             out_valid
);

    if (WIDTH < WidthMin || WIDTH > WidthMax) begin : g_bad_width
        $error("full_adder_cell: WIDTH must be in 1..64");
    end

    // Each stage owns its carry net so the chain is not one self-dependent vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic ci;
        logic co;
        logic s;

        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end

        fa_bit u_fa_bit (
            .s  (s),
            .co (co),
            .a  (a[i]),
            .b  (b[i]),
            .ci (ci)
        );

        assign sum[i] = s;
    end

    assign carry = g_bit[WIDTH-1].co;

    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             valid_d;

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sum;
            carry_d = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_full_adder_cell.sv
// Bench for full_adder_cell at WIDTH 1, 4 and 8; the 8-bit registered path
// is checked through an expected-result queue drained by a monitor process.
module tb_full_adder_cell;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       a1, b1, cin1, iv1;
    logic       sum1, carry1, sum_q1, carry_q1, ov1;
    // WIDTH=4 instance
    logic [3:0] a4, b4, sum4, sum_q4;
    logic       cin4, iv4, carry4, carry_q4, ov4;
    // WIDTH=8 instance
    logic [7:0] a8, b8, sum8, sum_q8;
    logic       cin8, iv8, carry8, carry_q8, ov8;

    full_adder_cell #(.WIDTH(1)) dut1 (
        .sum(sum1), .carry(carry1), .a(a1), .b(b1), .cin(cin1),
        .clk(clk), .rst_n(rst_n), .in_valid(iv1),
        .sum_q(sum_q1), .carry_q(carry_q1), .out_valid(ov1)
    );

    full_adder_cell #(.WIDTH(4)) dut4 (
        .sum(sum4), .carry(carry4), .a(a4), .b(b4), .cin(cin4),
        .clk(clk), .rst_n(rst_n), .in_valid(iv4),
        .sum_q(sum_q4), .carry_q(carry_q4), .out_valid(ov4)
    );

    full_adder_cell #(.WIDTH(8)) dut8 (
        .sum(sum8), .carry(carry8), .a(a8), .b(b8), .cin(cin8),
        .clk(clk), .rst_n(rst_n), .in_valid(iv8),
        .sum_q(sum_q8), .carry_q(carry_q8), .out_valid(ov8)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] last_exp = '0;
    logic       mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 8-bit registered path.
    initial begin
        logic iv_s, rst_s;
        logic [8:0] e;
        forever begin
            @(posedge clk);
            iv_s  = iv8;
            rst_s = rst_n;
            #1;
            if (mon_en) begin
                chk("w8_out_valid", 64'(ov8), 64'(iv_s & rst_s));
                if (ov8) begin
                    if (exp_q.size() == 0) begin
                        chk("w8_unexpected_result", 64'(ov8), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        last_exp = e;
                        chk("w8_result", 64'({carry_q8, sum_q8}), 64'(e));
                    end
                end else begin
                    chk("w8_hold", 64'({carry_q8, sum_q8}), 64'(last_exp));
                end
            end
        end
    end

    logic [1:0] sweep_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        logic [8:0] e;
        {a1, b1, cin1, iv1} = '0;
        {a4, b4, cin4, iv4} = '0;
        {a8, b8, cin8, iv8} = '0;

        #2;
        chk("rst_sum_q1", 64'(sum_q1), 64'(0));
        chk("rst_carry_q1", 64'(carry_q1), 64'(0));
        chk("rst_out_valid1", 64'(ov1), 64'(0));
        chk("rst_out_valid8", 64'(ov8), 64'(0));

        // Combinational sweep, done while still in reset.
        for (int v = 0; v < 8; v++) begin
            {a1, b1, cin1} = 3'(v);
            #5;
            chk($sformatf("sweep_%0d", v), 64'({carry1, sum1}), 64'(sweep_exp[v]));
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Capture then hold.
        {a1, b1, cin1} = 3'b111;
        iv1 = 1'b1;
        @(posedge clk); #1;
        chk("cap_sum_q", 64'(sum_q1), 64'(1));
        chk("cap_carry_q", 64'(carry_q1), 64'(1));
        chk("cap_out_valid", 64'(ov1), 64'(1));
        @(negedge clk);
        iv1 = 1'b0;
        {a1, b1, cin1} = 3'b000;
        @(posedge clk); #1;
        chk("hold_out_valid", 64'(ov1), 64'(0));
        chk("hold_sum_q", 64'(sum_q1), 64'(1));
        chk("hold_carry_q", 64'(carry_q1), 64'(1));

        // Ripple across all 4 bits.
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
        #1;
        chk("w4_f_plus_1", 64'({carry4, sum4}), 64'(5'h10));
        a4 = 4'h7; b4 = 4'h8; cin4 = 1'b1;
        #1;
        chk("w4_7_plus_8_plus_1", 64'({carry4, sum4}), 64'(5'h10));

        // Asynchronous reset between edges while a result is valid.
        @(negedge clk);
        {a1, b1, cin1} = 3'b101;
        iv1 = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_out_valid", 64'(ov1), 64'(1));
        chk("pre_rst_result", 64'({carry_q1, sum_q1}), 64'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum_q", 64'(sum_q1), 64'(0));
        chk("mid_rst_carry_q", 64'(carry_q1), 64'(0));
        chk("mid_rst_out_valid", 64'(ov1), 64'(0));
        {a1, b1, cin1} = 3'b100;
        #1;
        chk("rst_sum_tracks_a", 64'({carry1, sum1}), 64'(2'b01));
        {a1, b1, cin1} = 3'b011;
        #1;
        chk("rst_sum_tracks_bc", 64'({carry1, sum1}), 64'(2'b10));
        @(posedge clk); #1;
        chk("rst_held_out_valid", 64'(ov1), 64'(0));
        @(negedge clk);
        iv1 = 1'b0;
        rst_n = 1'b1;

        // Random 8-bit traffic through the registered path.
        mon_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            iv8  = 1'($urandom);
            e    = 9'(a8) + 9'(b8) + 9'(cin8);
            #1;
            chk("w8_comb", 64'({carry8, sum8}), 64'(e));
            if (iv8) exp_q.push_back(e);
        end
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("w8_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
